id_stage: RTL and testbench

Instruction-decode stage of the RV32I five-stage pipeline, sitting between the IF/ID register and the ID/EX register. It owns the 32×32 integer register file, with write-port bypass, and the immediate generator and main control decoder. It also detects load-use hazards and turns the current instruction into a bubble on a stall or flush. All datapath and control outputs connect one-to-one to the ID/EX register inputs.

---
 rtl/id_stage.sv | 161 ++++++++++++++++
 tb/tb_id_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I decode stage: register file with write bypass, immediate generator,
// control decoder and load-use hazard detection. `ID_STALL_CNT_EN adds a stall-cycle counter.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        valid_in,
    input  logic        flush_in,
    input  logic        wb_reg_wr_in,
    input  logic [4:0]  wb_rd_in,
    input  logic [31:0] wb_data_in,
    input  logic        id_ex_mem_rd_in,
    input  logic [4:0]  id_ex_rd_in,
    output logic [31:0] imm_out,
    output logic [4:0]  rs1_out,
    output logic [4:0]  rs2_out,
    output logic [4:0]  rd_out,
    output logic [6:0]  funct7_out,
    output logic [2:0]  funct3_out,
    output logic [31:0] val_A_out,
    output logic [31:0] val_B_out,
    output logic        ula_out,
    output logic        mux_res_ula_out,
    output logic        mem_rd_out,
    output logic        mem_wr_out,
    output logic        reg_wr_out,
    output logic        mux_reg_wr_out,
    output logic        stall_out,
    output logic        illegal_out,
    output logic [31:0] stall_cnt_out
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    logic [6:0]      opcode;
    logic            dec_ula, dec_mux_res, dec_mem_rd, dec_mem_wr, dec_reg_wr, dec_mux_wb;
    logic            dec_legal, use_rs1, use_rs2;
    logic            bubble, byp_en, hazard;
    logic [XLEN-1:0] rf_q [1:31];

    assign opcode     = instr_in[6:0];
    assign rd_out     = instr_in[11:7];
    assign funct3_out = instr_in[14:12];
    assign rs1_out    = instr_in[19:15];
    assign rs2_out    = instr_in[24:20];
    assign funct7_out = instr_in[31:25];

    // Main control decoder and immediate generator
    always_comb begin
        dec_ula     = 1'b0;
        dec_mux_res = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_reg_wr  = 1'b0;
        dec_mux_wb  = 1'b0;
        dec_legal   = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        imm_out     = '0;
        case (opcode)
            OP_R: begin
                dec_reg_wr = 1'b1;
                dec_legal  = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OP_IALU: begin
                dec_ula    = 1'b1;
                dec_reg_wr = 1'b1;
                dec_legal  = 1'b1;
                use_rs1    = 1'b1;
                imm_out    = {{20{instr_in[31]}}, instr_in[31:20]};
            end
            OP_LOAD: begin
                dec_ula    = 1'b1;
                dec_mem_rd = 1'b1;
                dec_reg_wr = 1'b1;
                dec_mux_wb = 1'b1;
                dec_legal  = 1'b1;
                use_rs1    = 1'b1;
                imm_out    = {{20{instr_in[31]}}, instr_in[31:20]};
            end
            OP_STORE: begin
                dec_ula    = 1'b1;
                dec_mem_wr = 1'b1;
                dec_legal  = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                imm_out    = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            end
            OP_LUI: begin
                dec_ula     = 1'b1;
                dec_mux_res = 1'b1;
                dec_reg_wr  = 1'b1;
                dec_legal   = 1'b1;
                imm_out     = {instr_in[31:12], 12'b0};
            end
            default: ;
        endcase
    end

    // Load-use hazard; a flush squashes the instruction so it never stalls
    assign hazard = id_ex_mem_rd_in && (id_ex_rd_in != RW'(0)) &&
                    ((use_rs1 && (id_ex_rd_in == rs1_out)) ||
                     (use_rs2 && (id_ex_rd_in == rs2_out)));
    assign stall_out = valid_in && !flush_in && !rst && hazard;
    assign bubble    = stall_out || flush_in || !valid_in || rst;

    assign ula_out         = dec_ula     && !bubble;
    assign mux_res_ula_out = dec_mux_res && !bubble;
    assign mem_rd_out      = dec_mem_rd  && !bubble;
    assign mem_wr_out      = dec_mem_wr  && !bubble;
    assign reg_wr_out      = dec_reg_wr  && !bubble;
    assign mux_reg_wr_out  = dec_mux_wb  && !bubble;
    assign illegal_out     = !dec_legal  && !bubble;

    // Register file: x0 is not stored, reset clears all entries and drops a coincident write
    assign byp_en = wb_reg_wr_in && (wb_rd_in != RW'(0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) rf_q[i] <= '0;
        end else if (byp_en) begin
            rf_q[wb_rd_in] <= wb_data_in;
        end
    end

    always_comb begin
        val_A_out = '0;
        val_B_out = '0;
        if (rs1_out != RW'(0))
            val_A_out = (byp_en && (wb_rd_in == rs1_out)) ? wb_data_in : rf_q[rs1_out];
        if (rs2_out != RW'(0))
            val_B_out = (byp_en && (wb_rd_in == rs2_out)) ? wb_data_in : rf_q[rs2_out];
    end

`ifdef ID_STALL_CNT_EN
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_out) stall_cnt_d = stall_cnt_q + XLEN'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_out = stall_cnt_q;
`else
    assign stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, regfile/bypass, decode, hazard, flush and illegal cases.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        valid_in, flush_in, wb_reg_wr_in, id_ex_mem_rd_in;
    logic [4:0]  wb_rd_in, id_ex_rd_in;
    logic [31:0] wb_data_in;
    logic [31:0] imm_out, val_A_out, val_B_out, stall_cnt_out;
    logic [4:0]  rs1_out, rs2_out, rd_out;
    logic [6:0]  funct7_out;
    logic [2:0]  funct3_out;
    logic        ula_out, mux_res_ula_out, mem_rd_out, mem_wr_out, reg_wr_out, mux_reg_wr_out;
    logic        stall_out, illegal_out;
    logic [5:0]  ctrl;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    assign ctrl = {ula_out, mux_res_ula_out, mem_rd_out, mem_wr_out, reg_wr_out, mux_reg_wr_out};

    id_stage dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .valid_in(valid_in), .flush_in(flush_in),
        .wb_reg_wr_in(wb_reg_wr_in), .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in),
        .id_ex_mem_rd_in(id_ex_mem_rd_in), .id_ex_rd_in(id_ex_rd_in),
        .imm_out(imm_out), .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
        .funct7_out(funct7_out), .funct3_out(funct3_out),
        .val_A_out(val_A_out), .val_B_out(val_B_out),
        .ula_out(ula_out), .mux_res_ula_out(mux_res_ula_out), .mem_rd_out(mem_rd_out),
        .mem_wr_out(mem_wr_out), .reg_wr_out(reg_wr_out), .mux_reg_wr_out(mux_reg_wr_out),
        .stall_out(stall_out), .illegal_out(illegal_out), .stall_cnt_out(stall_cnt_out)
    );

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    // Advance one rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b1; flush_in = 1'b0;
        wb_reg_wr_in = 1'b1; wb_rd_in = 5'd3; wb_data_in = 32'hCAFE_F00D;
        id_ex_mem_rd_in = 1'b1; id_ex_rd_in = 5'd7;
        instr_in = r_type(5'd8, 5'd7, 5'd1);
        step();
        checks++;
        if (ctrl !== 6'b0 || stall_out !== 1'b0 || illegal_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ctrl=%b stall=%b illegal=%b, expected all 0", ctrl, stall_out, illegal_out);
        end
        checks++;
        if (stall_cnt_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %h expected 0", stall_cnt_out);
        end
        wb_reg_wr_in = 1'b0; id_ex_mem_rd_in = 1'b0; id_ex_rd_in = 5'd0;
        step();
        rst = 1'b0;
        #1;
        for (int i = 1; i < 32; i++) begin
            instr_in = r_type(5'd0, 5'(i), 5'(i));
            #1;
            checks++;
            if (val_A_out !== 32'd0 || val_B_out !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg x%0d: A=%h B=%h expected 0", i, val_A_out, val_B_out);
            end
        end
    endtask

    task automatic test_bypass();
        wb_reg_wr_in = 1'b1; wb_rd_in = 5'd5; wb_data_in = 32'hDEAD_BEEF;
        instr_in = 32'h0002_8333;
        #1;
        checks++;
        if (val_A_out !== 32'hDEAD_BEEF || val_B_out !== 32'd0) begin
            errors++;
            $display("FAIL bypass_a: A=%h B=%h expected DEADBEEF/0", val_A_out, val_B_out);
        end
        checks++;
        if (rd_out !== 5'd6 || rs1_out !== 5'd5 || rs2_out !== 5'd0 || ctrl !== 6'b000010 || imm_out !== 32'd0) begin
            errors++;
            $display("FAIL add_decode: rd=%0d rs1=%0d rs2=%0d ctrl=%b imm=%h expected 6/5/0/000010/0",
                     rd_out, rs1_out, rs2_out, ctrl, imm_out);
        end
        step();
        wb_reg_wr_in = 1'b0; wb_data_in = 32'h0;
        #1;
        checks++;
        if (val_A_out !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL stored_x5: got %h expected DEADBEEF", val_A_out);
        end
        wb_reg_wr_in = 1'b1; wb_rd_in = 5'd9; wb_data_in = 32'h1357_2468;
        instr_in = r_type(5'd6, 5'd0, 5'd9);
        #1;
        checks++;
        if (val_B_out !== 32'h1357_2468 || val_A_out !== 32'd0) begin
            errors++;
            $display("FAIL bypass_b: A=%h B=%h expected 0/13572468", val_A_out, val_B_out);
        end
        step();
        wb_reg_wr_in = 1'b0;
        instr_in = r_type(5'd6, 5'd5, 5'd9);
        #1;
        checks++;
        if (val_A_out !== 32'hDEAD_BEEF || val_B_out !== 32'h1357_2468) begin
            errors++;
            $display("FAIL stored_pair: A=%h B=%h expected DEADBEEF/13572468", val_A_out, val_B_out);
        end
    endtask

    task automatic test_x0();
        wb_reg_wr_in = 1'b1; wb_rd_in = 5'd0; wb_data_in = 32'h0000_1234;
        instr_in = r_type(5'd1, 5'd0, 5'd0);
        #1;
        checks++;
        if (val_A_out !== 32'd0 || val_B_out !== 32'd0) begin
            errors++;
            $display("FAIL x0_bypass: A=%h B=%h expected 0", val_A_out, val_B_out);
        end
        step();
        wb_reg_wr_in = 1'b0;
        #1;
        checks++;
        if (val_A_out !== 32'd0) begin
            errors++;
            $display("FAIL x0_read: got %h expected 0", val_A_out);
        end
    endtask

    task automatic test_decode();
        instr_in = 32'hFFC1_2383;
        #1;
        checks++;
        if (imm_out !== 32'hFFFF_FFFC || ctrl !== 6'b101011 || rd_out !== 5'd7 || rs1_out !== 5'd2 || funct3_out !== 3'd2) begin
            errors++;
            $display("FAIL lw_decode: imm=%h ctrl=%b rd=%0d rs1=%0d f3=%0d expected FFFFFFFC/101011/7/2/2",
                     imm_out, ctrl, rd_out, rs1_out, funct3_out);
        end
        instr_in = {7'h7F, 5'd5, 5'd2, 3'b010, 5'd24, 7'b0100011};
        #1;
        checks++;
        if (imm_out !== 32'hFFFF_FFF8 || ctrl !== 6'b100100) begin
            errors++;
            $display("FAIL sw_neg: imm=%h ctrl=%b expected FFFFFFF8/100100", imm_out, ctrl);
        end
        instr_in = {7'h00, 5'd5, 5'd2, 3'b010, 5'd8, 7'b0100011};
        #1;
        checks++;
        if (imm_out !== 32'h0000_0008 || funct7_out !== 7'h00) begin
            errors++;
            $display("FAIL sw_pos: imm=%h f7=%h expected 00000008/00", imm_out, funct7_out);
        end
        instr_in = {20'hABCDE, 5'd10, 7'b0110111};
        #1;
        checks++;
        if (imm_out !== 32'hABCD_E000 || ctrl !== 6'b110010) begin
            errors++;
            $display("FAIL lui: imm=%h ctrl=%b expected ABCDE000/110010", imm_out, ctrl);
        end
        instr_in = {12'h801, 5'd3, 3'b000, 5'd8, 7'b0010011};
        #1;
        checks++;
        if (imm_out !== 32'hFFFF_F801 || ctrl !== 6'b100010) begin
            errors++;
            $display("FAIL addi: imm=%h ctrl=%b expected FFFFF801/100010", imm_out, ctrl);
        end
    endtask

    task automatic test_stall();
        id_ex_mem_rd_in = 1'b1; id_ex_rd_in = 5'd7;
        instr_in = r_type(5'd8, 5'd7, 5'd1);
        #1;
        checks++;
        if (stall_out !== 1'b1 || ctrl !== 6'b0 || rs1_out !== 5'd7) begin
            errors++;
            $display("FAIL stall_rs1: stall=%b ctrl=%b rs1=%0d expected 1/000000/7", stall_out, ctrl, rs1_out);
        end
        step();
        id_ex_mem_rd_in = 1'b0;
        #1;
        checks++;
        if (stall_out !== 1'b0 || ctrl !== 6'b000010) begin
            errors++;
            $display("FAIL stall_release: stall=%b ctrl=%b expected 0/000010", stall_out, ctrl);
        end
`ifdef ID_STALL_CNT_EN
        exp_cnt = 32'd1;
`else
        exp_cnt = 32'd0;
`endif
        checks++;
        if (stall_cnt_out !== exp_cnt) begin
            errors++;
            $display("FAIL stall_cnt: got %h expected %h", stall_cnt_out, exp_cnt);
        end
        id_ex_mem_rd_in = 1'b1; id_ex_rd_in = 5'd1;
        #1;
        checks++;
        if (stall_out !== 1'b1) begin
            errors++;
            $display("FAIL stall_rs2: got %b expected 1", stall_out);
        end
        instr_in = {12'd1, 5'd3, 3'b000, 5'd8, 7'b0010011};
        #1;
        checks++;
        if (stall_out !== 1'b0 || ctrl !== 6'b100010) begin
            errors++;
            $display("FAIL addi_no_rs2: stall=%b ctrl=%b expected 0/100010", stall_out, ctrl);
        end
        id_ex_rd_in = 5'd0;
        instr_in = r_type(5'd8, 5'd0, 5'd0);
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_x0: got %b expected 0", stall_out);
        end
        id_ex_mem_rd_in = 1'b0;
    endtask

    task automatic test_flush();
        id_ex_mem_rd_in = 1'b1; id_ex_rd_in = 5'd7; flush_in = 1'b1;
        instr_in = r_type(5'd8, 5'd7, 5'd1);
        #1;
        checks++;
        if (stall_out !== 1'b0 || ctrl !== 6'b0) begin
            errors++;
            $display("FAIL flush: stall=%b ctrl=%b expected 0/000000", stall_out, ctrl);
        end
        flush_in = 1'b0; valid_in = 1'b0;
        #1;
        checks++;
        if (stall_out !== 1'b0 || ctrl !== 6'b0) begin
            errors++;
            $display("FAIL invalid: stall=%b ctrl=%b expected 0/000000", stall_out, ctrl);
        end
        valid_in = 1'b1; id_ex_mem_rd_in = 1'b0;
    endtask

    task automatic test_illegal();
        instr_in = {25'h0AB_CDEF, 7'b1111111};
        #1;
        checks++;
        if (illegal_out !== 1'b1 || ctrl !== 6'b0 || imm_out !== 32'd0) begin
            errors++;
            $display("FAIL illegal: ill=%b ctrl=%b imm=%h expected 1/000000/0", illegal_out, ctrl, imm_out);
        end
        valid_in = 1'b0;
        #1;
        checks++;
        if (illegal_out !== 1'b0) begin
            errors++;
            $display("FAIL illegal_bubble: got %b expected 0", illegal_out);
        end
        valid_in = 1'b1; flush_in = 1'b1;
        #1;
        checks++;
        if (illegal_out !== 1'b0) begin
            errors++;
            $display("FAIL illegal_flush: got %b expected 0", illegal_out);
        end
        flush_in = 1'b0;
    endtask

    initial begin
        #3;
        test_reset();
        test_bypass();
        test_x0();
        test_decode();
        test_stall();
        test_flush();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1);
    end
endmodule
